rs_param_station: RTL

- Parametrised successor to the single-ALU reservation station. Holds DEPTH dispatched ops, captures operands from NUM_WB broadcast buses and issues one ready op per cycle to the ALU through a valid/ready handshake.
- Sits between the instruction fetcher/dispatcher and the ALU.
- New relative to the previous generation:
  - explicit per-operand dependency valid bits, so ROB id 0 is a legal tag;
  - same-cycle wakeup bypass on dispatch;
  - backpressure through a handshake;
  - an occupancy count.

---
 rtl/rs_param_station.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_param_station.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rs_param_station                                                |
// | Purpose  : Parametrised reservation station. Holds DEPTH dispatched ops,   |
// |            captures pending operands from NUM_WB wakeup buses and issues   |
// |            one ready op per cycle to the ALU through a valid/ready         |
// |            handshake.                                                      |
// | Options  : RS_AGE_ISSUE_EN - oldest-first issue using per-entry ages;      |
// |            when undefined, the lowest-index ready entry issues.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rs_param_station #(
  parameter int DEPTH  = 32,
  parameter int ROB_W  = 5,
  parameter int NUM_WB = 5,
  parameter int XLEN   = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_type,
  input  logic [3:0]                in_op,
  input  logic [ROB_W-1:0]          in_rob_id,
  input  logic [XLEN-1:0]           in_r1,
  input  logic [XLEN-1:0]           in_r2,
  input  logic [XLEN-1:0]           in_imm,
  input  logic                      in_use_imm,
  input  logic                      in_dep1_v,
  input  logic [ROB_W-1:0]          in_dep1,
  input  logic                      in_dep2_v,
  input  logic [ROB_W-1:0]          in_dep2,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*ROB_W-1:0]   wb_tag,
  input  logic [NUM_WB*XLEN-1:0]    wb_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROB_W-1:0]          out_rob_id,
  output logic [6:0]                out_type,
  output logic [3:0]                out_op,
  output logic [XLEN-1:0]           out_v1,
  output logic [XLEN-1:0]           out_v2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int              C_IDX_W = $clog2(DEPTH);
  localparam int              C_CNT_W = C_IDX_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]   valid_q,   valid_d;
  logic [DEPTH-1:0]   use_imm_q, use_imm_d;
  logic [DEPTH-1:0]   dep1_v_q,  dep1_v_d;
  logic [DEPTH-1:0]   dep2_v_q,  dep2_v_d;
  logic [6:0]         type_q   [DEPTH];
  logic [6:0]         type_d   [DEPTH];
  logic [3:0]         op_q     [DEPTH];
  logic [3:0]         op_d     [DEPTH];
  logic [ROB_W-1:0]   rob_id_q [DEPTH];
  logic [ROB_W-1:0]   rob_id_d [DEPTH];
  logic [ROB_W-1:0]   dep1_q   [DEPTH];
  logic [ROB_W-1:0]   dep1_d   [DEPTH];
  logic [ROB_W-1:0]   dep2_q   [DEPTH];
  logic [ROB_W-1:0]   dep2_d   [DEPTH];
  logic [XLEN-1:0]    r1_q     [DEPTH];
  logic [XLEN-1:0]    r1_d     [DEPTH];
  logic [XLEN-1:0]    r2_q     [DEPTH];
  logic [XLEN-1:0]    r2_d     [DEPTH];
  logic [XLEN-1:0]    imm_q    [DEPTH];
  logic [XLEN-1:0]    imm_d    [DEPTH];
`ifdef RS_AGE_ISSUE_EN
  logic [C_IDX_W-1:0] age_q    [DEPTH];
  logic [C_IDX_W-1:0] age_d    [DEPTH];
  logic [C_IDX_W-1:0] sel_age_w;
  logic [C_CNT_W-1:0] ins_age_w;
`endif
  logic [C_CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0]   ready_w;
  logic               sel_found_w;
  logic [C_IDX_W-1:0] sel_idx_w;
  logic               free_found_w;
  logic [C_IDX_W-1:0] free_idx_w;
  logic               accept_w;
  logic               pop_w;
  logic [XLEN-1:0]    byp_r1_w, byp_r2_w;
  logic               byp_dep1_v_w, byp_dep2_v_w;

  assign ready_w   = valid_q & ~dep1_v_q & ~dep2_v_q;
  assign in_ready  = (count_q < C_DEPTH) && !flush_in;
  assign out_valid = rdy_in && !flush_in && sel_found_w;
  assign accept_w  = in_valid && in_ready && rdy_in && free_found_w;
  assign pop_w     = out_valid && out_ready;
  assign count     = count_q;

  // Issue selection: oldest ready entry, or lowest-index ready entry
  always_comb begin
    sel_found_w = 1'b0;
    sel_idx_w   = '0;
`ifdef RS_AGE_ISSUE_EN
    sel_age_w   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_w[i] && (!sel_found_w || (age_q[i] < sel_age_w))) begin
        sel_found_w = 1'b1;
        sel_idx_w   = C_IDX_W'(i);
        sel_age_w   = age_q[i];
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_w[i] && !sel_found_w) begin
        sel_found_w = 1'b1;
        sel_idx_w   = C_IDX_W'(i);
      end
    end
`endif
  end

  // Lowest-index slot free at the start of the cycle receives a dispatch
  always_comb begin
    free_found_w = 1'b0;
    free_idx_w   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found_w) begin
        free_found_w = 1'b1;
        free_idx_w   = C_IDX_W'(i);
      end
    end
  end

  // Dispatch bypass: resolve incoming pending operands against this cycle's broadcasts
  always_comb begin
    byp_r1_w     = in_r1;
    byp_r2_w     = in_r2;
    byp_dep1_v_w = in_dep1_v;
    byp_dep2_v_w = in_dep2_v;
    for (int k = 0; k < NUM_WB; k++) begin
      if (in_dep1_v && wb_valid[k] && (wb_tag[k*ROB_W +: ROB_W] == in_dep1)) begin
        byp_r1_w     = wb_value[k*XLEN +: XLEN];
        byp_dep1_v_w = 1'b0;
      end
      if (in_dep2_v && wb_valid[k] && (wb_tag[k*ROB_W +: ROB_W] == in_dep2)) begin
        byp_r2_w     = wb_value[k*XLEN +: XLEN];
        byp_dep2_v_w = 1'b0;
      end
    end
  end

  // Present the selected entry; all fields read zero when nothing issues
  always_comb begin
    out_rob_id = '0;
    out_type   = '0;
    out_op     = '0;
    out_v1     = '0;
    out_v2     = '0;
    if (out_valid) begin
      out_rob_id = rob_id_q[sel_idx_w];
      out_type   = type_q[sel_idx_w];
      out_op     = op_q[sel_idx_w];
      out_v1     = r1_q[sel_idx_w];
      out_v2     = use_imm_q[sel_idx_w] ? imm_q[sel_idx_w] : r2_q[sel_idx_w];
    end
  end

  // Next-state: flush, else wakeup, pop and insert (all frozen while rdy_in is low)
  always_comb begin
    valid_d   = valid_q;
    use_imm_d = use_imm_q;
    dep1_v_d  = dep1_v_q;
    dep2_v_d  = dep2_v_q;
    type_d    = type_q;
    op_d      = op_q;
    rob_id_d  = rob_id_q;
    dep1_d    = dep1_q;
    dep2_d    = dep2_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    imm_d     = imm_q;
    count_d   = count_q;
`ifdef RS_AGE_ISSUE_EN
    age_d     = age_q;
    ins_age_w = count_q - {{(C_CNT_W-1){1'b0}}, pop_w};
`endif
    if (flush_in) begin
      valid_d = '0;
      count_d = '0;
    end else if (rdy_in) begin
      // Later ports override earlier ones; matching ports carry the same value
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (valid_q[i] && dep1_v_q[i] && wb_valid[k] &&
              (wb_tag[k*ROB_W +: ROB_W] == dep1_q[i])) begin
            r1_d[i]     = wb_value[k*XLEN +: XLEN];
            dep1_v_d[i] = 1'b0;
          end
          if (valid_q[i] && dep2_v_q[i] && wb_valid[k] &&
              (wb_tag[k*ROB_W +: ROB_W] == dep2_q[i])) begin
            r2_d[i]     = wb_value[k*XLEN +: XLEN];
            dep2_v_d[i] = 1'b0;
          end
        end
      end
      if (pop_w) begin
        valid_d[sel_idx_w] = 1'b0;
`ifdef RS_AGE_ISSUE_EN
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (age_q[i] > sel_age_w)) begin
            age_d[i] = age_q[i] - 1'b1;
          end
        end
`endif
      end
      if (accept_w) begin
        valid_d[free_idx_w]   = 1'b1;
        type_d[free_idx_w]    = in_type;
        op_d[free_idx_w]      = in_op;
        rob_id_d[free_idx_w]  = in_rob_id;
        r1_d[free_idx_w]      = byp_r1_w;
        r2_d[free_idx_w]      = byp_r2_w;
        imm_d[free_idx_w]     = in_imm;
        use_imm_d[free_idx_w] = in_use_imm;
        dep1_v_d[free_idx_w]  = byp_dep1_v_w;
        dep1_d[free_idx_w]    = in_dep1;
        dep2_v_d[free_idx_w]  = byp_dep2_v_w;
        dep2_d[free_idx_w]    = in_dep2;
`ifdef RS_AGE_ISSUE_EN
        age_d[free_idx_w]     = ins_age_w[C_IDX_W-1:0];
`endif
      end
      count_d = count_q + {{(C_CNT_W-1){1'b0}}, accept_w}
                        - {{(C_CNT_W-1){1'b0}}, pop_w};
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q   <= '0;
      use_imm_q <= '0;
      dep1_v_q  <= '0;
      dep2_v_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i]   <= '0;
        op_q[i]     <= '0;
        rob_id_q[i] <= '0;
        dep1_q[i]   <= '0;
        dep2_q[i]   <= '0;
        r1_q[i]     <= '0;
        r2_q[i]     <= '0;
        imm_q[i]    <= '0;
`ifdef RS_AGE_ISSUE_EN
        age_q[i]    <= '0;
`endif
      end
    end else begin
      valid_q   <= valid_d;
      use_imm_q <= use_imm_d;
      dep1_v_q  <= dep1_v_d;
      dep2_v_q  <= dep2_v_d;
      count_q   <= count_d;
      type_q    <= type_d;
      op_q      <= op_d;
      rob_id_q  <= rob_id_d;
      dep1_q    <= dep1_d;
      dep2_q    <= dep2_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      imm_q     <= imm_d;
`ifdef RS_AGE_ISSUE_EN
      age_q     <= age_d;
`endif
    end
  end

endmodule
`default_nettype wire
